// File: rtl/calc_pkg.sv
// calc_pkg: state and operation encodings shared by the calculator sequencer.
// The multiply path is enabled by defining CALC_MUL_EN.
package calc_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_EXEC = 2'd1;
   localparam state_t ST_MUL  = 2'd2;
   localparam state_t ST_DONE = 2'd3;

   typedef logic [1:0] op_t;

   localparam op_t OP_ADD = 2'b00;
   localparam op_t OP_SUB = 2'b01;
   localparam op_t OP_MUL = 2'b10;
   localparam op_t OP_ILL = 2'b11;

endpackage

// File: rtl/calc_mul_seq.sv
// calc_mul_seq: W-cycle shift-add multiplier. o_product_c is the accumulator
// value after the current cycle's add, so the parent can capture the final
// product on the same edge that retires the last step (o_last_c high).
module calc_mul_seq #(
   parameter int unsigned W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic [W-1:0]     i_a,
   input  logic [W-1:0]     i_b,
   output logic             o_last_c,
   output logic [2*W-1:0]   o_product_c
);

   localparam int unsigned PW = 2 * W;
   localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

   logic [PW-1:0] r_acc;
   logic [PW-1:0] r_mcand;
   logic [W-1:0]  r_mplier;
   logic [CW-1:0] r_cnt;
   logic          r_run;
   logic [PW-1:0] w_sum;

   // Partial-product add for the current multiplier bit.
   always_comb begin
      w_sum       = r_acc + (r_mplier[0] ? r_mcand : '0);
      o_product_c = w_sum;
      o_last_c    = r_run && (r_cnt == CW'(W - 1));
   end

   // Accumulator, shifting operands and step counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
         r_run    <= 1'b0;
      end else if (i_start) begin
         r_acc    <= '0;
         r_mcand  <= PW'(i_a);
         r_mplier <= i_b;
         r_cnt    <= '0;
         r_run    <= 1'b1;
      end else if (r_run) begin
         r_acc    <= w_sum;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + CW'(1);
         if (o_last_c) begin
            r_run <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/calc_alu_seq.sv
// calc_alu_seq: operand/operation sequencer for the 2-bit add/sub calculator.
// Define CALC_MUL_EN to enable the shift-add multiply for op 10; otherwise
// op 10 completes as an illegal operation.
module calc_alu_seq
   import calc_pkg::*;
#(
   parameter int unsigned W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [W-1:0]     inA,
   input  logic [W-1:0]     inB,
   input  logic             btnLoadA,
   input  logic             btnLoadB,
   input  logic             btnGo,
   input  logic [1:0]       op_sel,
   output logic [W-1:0]     alu_a,
   output logic [W-1:0]     alu_b,
   output logic             alu_op,
   input  logic [W:0]       alu_res,
   output logic [2*W-1:0]   result,
   output logic             carry_borrow,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int unsigned RW = 2 * W;

   logic          r_prev_a, r_prev_b, r_prev_go;
   logic          w_edge_a, w_edge_b, w_edge_go;
   logic          w_ready, w_go;
   state_t        r_state, w_state_nx;
   logic [W-1:0]  r_reg_a, r_reg_b, w_reg_a_nx, w_reg_b_nx;
   op_t           r_op, w_op_nx;
   logic [RW-1:0] r_result, w_result_nx, w_res_zext, w_res_sext;
   logic          r_cb, w_cb_nx;
   logic          r_busy, w_busy_nx;
   logic          r_done, w_done_nx;
   logic          r_err, w_err_nx;
   logic          r_alu_op, w_alu_op_nx;

`ifdef CALC_MUL_EN
   logic          w_mul_start;
   logic          w_mul_last;
   logic [RW-1:0] w_mul_prod;

   calc_mul_seq #(.W(W)) u_mul (
      .clk         (clk),
      .rst         (rst),
      .i_start     (w_mul_start),
      .i_a         (w_reg_a_nx),
      .i_b         (w_reg_b_nx),
      .o_last_c    (w_mul_last),
      .o_product_c (w_mul_prod)
   );
`endif

   // Button edges, operand loads and go acceptance (only when not busy).
   always_comb begin
      w_edge_a   = btnLoadA & ~r_prev_a;
      w_edge_b   = btnLoadB & ~r_prev_b;
      w_edge_go  = btnGo & ~r_prev_go;
      w_ready    = (r_state == ST_IDLE) || (r_state == ST_DONE);
      w_go       = w_edge_go && w_ready;
      w_reg_a_nx = (w_edge_a && w_ready) ? inA : r_reg_a;
      w_reg_b_nx = (w_edge_b && w_ready) ? inB : r_reg_b;
      w_op_nx    = w_go ? op_sel : r_op;
      w_res_zext = RW'(alu_res);
      w_res_sext = RW'($signed(alu_res));
   end

   // Next-state and registered-output logic.
   always_comb begin
      w_state_nx  = r_state;
      w_result_nx = r_result;
      w_cb_nx     = r_cb;
      w_done_nx   = 1'b0;
      w_err_nx    = r_err;
`ifdef CALC_MUL_EN
      w_mul_start = 1'b0;
`endif
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (w_go) begin
               w_err_nx = 1'b0;
               case (op_sel)
                  OP_ADD, OP_SUB: w_state_nx = ST_EXEC;
`ifdef CALC_MUL_EN
                  OP_MUL: begin
                     w_state_nx  = ST_MUL;
                     w_mul_start = 1'b1;
                  end
`endif
                  default: begin
                     w_state_nx  = ST_DONE;
                     w_result_nx = '0;
                     w_cb_nx     = 1'b0;
                     w_err_nx    = 1'b1;
                     w_done_nx   = 1'b1;
                  end
               endcase
            end
         end
         ST_EXEC: begin
            w_result_nx = (r_op == OP_SUB) ? w_res_sext : w_res_zext;
            w_cb_nx     = alu_res[W];
            w_done_nx   = 1'b1;
            w_state_nx  = ST_DONE;
         end
`ifdef CALC_MUL_EN
         ST_MUL: begin
            if (w_mul_last) begin
               w_result_nx = w_mul_prod;
               w_cb_nx     = 1'b0;
               w_done_nx   = 1'b1;
               w_state_nx  = ST_DONE;
            end
         end
`endif
         default: w_state_nx = ST_IDLE;
      endcase

      w_busy_nx = (w_state_nx == ST_EXEC);
`ifdef CALC_MUL_EN
      w_busy_nx = w_busy_nx || (w_state_nx == ST_MUL);
`endif
      w_alu_op_nx = (w_state_nx == ST_EXEC) && w_op_nx[0];
   end

   // State, operand and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_prev_a  <= 1'b0;
         r_prev_b  <= 1'b0;
         r_prev_go <= 1'b0;
         r_state   <= ST_IDLE;
         r_reg_a   <= '0;
         r_reg_b   <= '0;
         r_op      <= OP_ADD;
         r_result  <= '0;
         r_cb      <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_alu_op  <= 1'b0;
      end else begin
         r_prev_a  <= btnLoadA;
         r_prev_b  <= btnLoadB;
         r_prev_go <= btnGo;
         r_state   <= w_state_nx;
         r_reg_a   <= w_reg_a_nx;
         r_reg_b   <= w_reg_b_nx;
         r_op      <= w_op_nx;
         r_result  <= w_result_nx;
         r_cb      <= w_cb_nx;
         r_busy    <= w_busy_nx;
         r_done    <= w_done_nx;
         r_err     <= w_err_nx;
         r_alu_op  <= w_alu_op_nx;
      end
   end

   assign alu_a        = r_reg_a;
   assign alu_b        = r_reg_b;
   assign alu_op       = r_alu_op;
   assign result       = r_result;
   assign carry_borrow = r_cb;
   assign busy         = r_busy;
   assign done         = r_done;
   assign err          = r_err;

endmodule

// File: tb/tb_calc_alu_seq.sv
// tb_calc_alu_seq: directed and random stimulus for calc_alu_seq against a
// transaction-level model (operands, remaining busy cycles, pending result).
module tb_calc_alu_seq;

   localparam int unsigned W  = 2;
   localparam int unsigned RW = 2 * W;
`ifdef CALC_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  inA, inB;
   logic          btnLoadA, btnLoadB, btnGo;
   logic [1:0]    op_sel;
   logic [W-1:0]  alu_a, alu_b;
   logic          alu_op;
   logic [W:0]    alu_res;
   logic [RW-1:0] result;
   logic          carry_borrow, busy, done, err;

   int total = 0;
   int bad   = 0;

   // Behavioural model state.
   logic [W-1:0]  m_a, m_b;
   int            m_left;
   logic [RW-1:0] m_res, m_pend;
   logic          m_cb, m_pend_cb, m_done, m_err, m_aluop;
   logic          m_pa, m_pb, m_pg;

   always #5 clk = ~clk;

   // External combinational add/sub ALU.
   assign alu_res = alu_op ? ({1'b0, alu_a} - {1'b0, alu_b})
                           : ({1'b0, alu_a} + {1'b0, alu_b});

   calc_alu_seq #(.W(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .inA          (inA),
      .inB          (inB),
      .btnLoadA     (btnLoadA),
      .btnLoadB     (btnLoadB),
      .btnGo        (btnGo),
      .op_sel       (op_sel),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_op       (alu_op),
      .alu_res      (alu_res),
      .result       (result),
      .carry_borrow (carry_borrow),
      .busy         (busy),
      .done         (done),
      .err          (err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_a = '0; m_b = '0; m_left = 0;
      m_res = '0; m_pend = '0; m_cb = 1'b0; m_pend_cb = 1'b0;
      m_done = 1'b0; m_err = 1'b0; m_aluop = 1'b0;
      m_pa = 1'b0; m_pb = 1'b0; m_pg = 1'b0;
   endtask

   // One clock edge of the calculator as seen by a user.
   task automatic model_step();
      logic ea, eb, eg;
      int   s;
      if (!rst) begin
         model_reset();
         return;
      end
      ea = btnLoadA && !m_pa;
      eb = btnLoadB && !m_pb;
      eg = btnGo && !m_pg;
      m_pa = btnLoadA; m_pb = btnLoadB; m_pg = btnGo;
      m_done  = 1'b0;
      m_aluop = 1'b0;
      if (m_left > 0) begin
         m_left--;
         if (m_left == 0) begin
            m_res  = m_pend;
            m_cb   = m_pend_cb;
            m_done = 1'b1;
         end
      end else begin
         if (ea) m_a = inA;
         if (eb) m_b = inB;
         if (eg) begin
            m_err = 1'b0;
            if (op_sel == 2'd0) begin
               s = int'(m_a) + int'(m_b);
               m_pend = RW'(s); m_pend_cb = (s >= (1 << W)); m_left = 1;
            end else if (op_sel == 2'd1) begin
               s = int'(m_a) - int'(m_b);
               m_pend = RW'(s); m_pend_cb = (m_a < m_b); m_left = 1; m_aluop = 1'b1;
            end else if (op_sel == 2'd2 && MUL_EN) begin
               s = int'(m_a) * int'(m_b);
               m_pend = RW'(s); m_pend_cb = 1'b0; m_left = W;
            end else begin
               m_res = '0; m_cb = 1'b0; m_err = 1'b1; m_done = 1'b1;
            end
         end
      end
   endtask

   task automatic check_cycle();
      chk("result", 32'(result), 32'(m_res));
      chk("carry_borrow", 32'(carry_borrow), 32'(m_cb));
      chk("busy", 32'(busy), 32'(m_left > 0));
      chk("done", 32'(done), 32'(m_done));
      chk("err", 32'(err), 32'(m_err));
      chk("alu_a", 32'(alu_a), 32'(m_a));
      chk("alu_b", 32'(alu_b), 32'(m_b));
      chk("alu_op", 32'(alu_op), 32'(m_aluop));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_cycle();
   endtask

   task automatic load_a(input logic [W-1:0] v);
      inA = v; btnLoadA = 1'b1; tick(); btnLoadA = 1'b0; tick();
   endtask

   task automatic load_b(input logic [W-1:0] v);
      inB = v; btnLoadB = 1'b1; tick(); btnLoadB = 1'b0; tick();
   endtask

   task automatic go(input logic [1:0] op);
      op_sel = op; btnGo = 1'b1; tick(); btnGo = 1'b0;
   endtask

   initial begin
      rst = 1'b0; inA = '0; inB = '0; op_sel = '0;
      btnLoadA = 1'b0; btnLoadB = 1'b0; btnGo = 1'b0;
      model_reset();
      tick(); tick();
      chk("rst_result", 32'(result), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      rst = 1'b1;
      tick();

      // 2 + 3
      load_a(2'd2); load_b(2'd3); go(2'd0);
      chk("add_busy", 32'(busy), 1);
      tick();
      chk("add_result", 32'(result), 32'h5);
      chk("add_cb", 32'(carry_borrow), 1);
      chk("add_done", 32'(done), 1);
      chk("model_add", 32'(m_res), 32'h5);
      tick();
      chk("add_done_once", 32'(done), 0);

      // 1 - 2, then 3 - 1
      load_a(2'd1); load_b(2'd2); go(2'd1); tick();
      chk("sub_neg_result", 32'(result), 32'hf);
      chk("sub_neg_cb", 32'(carry_borrow), 1);
      chk("model_sub", 32'(m_res), 32'hf);
      load_a(2'd3); load_b(2'd1); go(2'd1); tick();
      chk("sub_pos_result", 32'(result), 32'h2);
      chk("sub_pos_cb", 32'(carry_borrow), 0);

      // 3 * 3 with a load and go attempted mid-operation
      load_a(2'd3); load_b(2'd3); go(2'd2);
`ifdef CALC_MUL_EN
      chk("mul_busy1", 32'(busy), 1);
      inB = 2'd0; btnLoadB = 1'b1; btnGo = 1'b1; tick();
      chk("mul_busy2", 32'(busy), 1);
      chk("mul_nodone", 32'(done), 0);
      btnLoadB = 1'b0; btnGo = 1'b0; tick();
      chk("mul_result", 32'(result), 32'h9);
      chk("mul_cb", 32'(carry_borrow), 0);
      chk("mul_done", 32'(done), 1);
      chk("mul_b_kept", 32'(alu_b), 32'h3);
      chk("model_mul", 32'(m_res), 32'h9);
      tick();
      chk("mul_done_once", 32'(done), 0);
`else
      chk("mul_off_err", 32'(err), 1);
      chk("mul_off_result", 32'(result), 0);
      chk("mul_off_busy", 32'(busy), 0);
      tick();
`endif

      // Illegal op, then a legal go clears err
      tick();
      go(2'd3);
      chk("ill_done", 32'(done), 1);
      chk("ill_err", 32'(err), 1);
      chk("ill_busy", 32'(busy), 0);
      chk("ill_result", 32'(result), 0);
      tick();
      go(2'd0);
      chk("ill_err_clear", 32'(err), 0);
      tick(); tick();

      // Reset during the first cycle of a multiply
      go(2'd2);
      rst = 1'b0;
      #1;
      model_reset();
      chk("midrst_result", 32'(result), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_alu_a", 32'(alu_a), 0);
      chk("midrst_err", 32'(err), 0);
      tick();
      rst = 1'b1;
      repeat (4) tick();
      chk("midrst_idle", 32'(busy), 0);

      // Loads on the same edge as go feed the operation
      inA = 2'd1; inB = 2'd1; op_sel = 2'd0;
      btnLoadA = 1'b1; btnLoadB = 1'b1; btnGo = 1'b1;
      tick();
      btnLoadA = 1'b0; btnLoadB = 1'b0; btnGo = 1'b0;
      tick();
      chk("same_edge_result", 32'(result), 32'h2);

      // Random button activity
      for (int i = 0; i < 3000; i++) begin
         inA      = W'($urandom);
         inB      = W'($urandom);
         op_sel   = 2'($urandom);
         btnLoadA = ($urandom_range(0, 3) == 0);
         btnLoadB = ($urandom_range(0, 3) == 0);
         btnGo    = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 299) == 0) begin
            rst = 1'b0;
            #1;
            model_reset();
            tick();
            rst = 1'b1;
         end else begin
            tick();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
